// File: rtl/arrow_pkg.sv
// Shared definitions for the falling-arrow sequencing logic.
//   NUM_LANES    : number of arrow lanes (left, down, up, right)
//   Y_W          : width of a lane's y offset
//   LANE_L/D/U/R : lane index constants
//   lane_state_e : per-lane state (IDLE = no arrow, LIVE = arrow on screen)
//   count4       : population count of a 4-bit lane vector
package arrow_pkg;

    localparam int NUM_LANES = 4;
    localparam int Y_W       = 8;

    localparam logic [1:0] LANE_L = 2'd0;
    localparam logic [1:0] LANE_D = 2'd1;
    localparam logic [1:0] LANE_U = 2'd2;
    localparam logic [1:0] LANE_R = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        LIVE = 1'b1
    } lane_state_e;

    function automatic logic [2:0] count4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/arrow_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin arbiter.
// The lane at index ptr has top priority, then ptr+1, ptr+2, ptr+3 (mod 4).
// Ports:
//   req   in  4  request vector
//   ptr   in  2  index of the highest-priority lane
//   grant out 4  one-hot grant (zero when no request)
//   valid out 1  at least one request present
module rr_arbiter4
    import arrow_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic                 valid
);

    logic [1:0] idx;

    // Walk from lowest priority to highest so the last match (closest to
    // ptr) overwrites any earlier one.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/arrow_scheduler.sv
// arrow_scheduler: spawn / advance / retire / hit-judge controller for the
// four falling-arrow lanes of the rhythm-game display.
// Ports:
//   pclk         in   1  pixel clock, only clock
//   rst_n        in   1  synchronous active-low reset
//   frame_tick   in   1  one-cycle pulse per video frame
//   spawn_req    in   4  lane i requests a spawn (sampled on frame_tick only)
//   hit          in   4  one-cycle debounced key press for lane i
//   lane_visible out  4  lane i arrow live
//   lane_y       out 32  lane i y offset at [8i+7:8i]
//   spawn_pulse  out  4  lane i spawned
//   hit_pulse    out  4  lane i press judged a hit
//   miss_pulse   out  4  lane i arrow retired unhit, or press was wrong
//   score        out 16  saturating hit count
module arrow_scheduler
    import arrow_pkg::*;
#(
    parameter int STEP       = 1,
    parameter int Y_MAX      = 199,
    parameter int HIT_LO     = 160,
    parameter int HIT_HI     = 199,
    parameter int MIN_GAP    = 8,
    parameter int MAX_ACTIVE = 3
) (
    input  logic                     pclk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic [NUM_LANES-1:0]     spawn_req,
    input  logic [NUM_LANES-1:0]     hit,
    output logic [NUM_LANES-1:0]     lane_visible,
    output logic [NUM_LANES*Y_W-1:0] lane_y,
    output logic [NUM_LANES-1:0]     spawn_pulse,
    output logic [NUM_LANES-1:0]     hit_pulse,
    output logic [NUM_LANES-1:0]     miss_pulse,
    output logic [15:0]              score
);

    // Comparisons are done at Y_W+1 bits so y+STEP cannot wrap.
    localparam logic [Y_W:0] STEP_C   = (Y_W + 1)'(STEP);
    localparam logic [Y_W:0] Y_MAX_C  = (Y_W + 1)'(Y_MAX);
    localparam logic [Y_W:0] HIT_LO_C = (Y_W + 1)'(HIT_LO);
    localparam logic [Y_W:0] HIT_HI_C = (Y_W + 1)'(HIT_HI);

    logic [NUM_LANES-1:0] live;
    logic [NUM_LANES-1:0] hit_ok;
    logic [NUM_LANES-1:0] wrong_press;
    logic [NUM_LANES-1:0] retire;
    logic [NUM_LANES-1:0] spawn_grant;

    logic [NUM_LANES-1:0] arb_grant;
    logic                 arb_valid;
    logic [1:0]           winner;
    logic [2:0]           active_after;
    logic                 spawn_ok;

    logic [7:0]  gap_reg,   gap_next;
    logic [1:0]  ptr_reg,   ptr_next;
    logic [15:0] score_reg, score_next;
    logic [16:0] score_sum;

    logic [NUM_LANES-1:0] spawn_pulse_reg;
    logic [NUM_LANES-1:0] hit_pulse_reg;
    logic [NUM_LANES-1:0] miss_pulse_reg;

    // ------------------------------------------------------------------
    // Per-lane state, judging and motion
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : lane_g
            lane_state_e    state_reg, state_next;
            logic [Y_W-1:0] y_reg,     y_next;
            logic [Y_W:0]   y_ext;
            logic [Y_W:0]   y_sum;
            logic           advance;

            assign y_ext    = {1'b0, y_reg};
            assign y_sum    = y_ext + STEP_C;
            assign live[gi] = (state_reg == LIVE);

            // Hits are judged on the pre-tick y, so a hit takes priority
            // over a coincident retire or advance.
            assign hit_ok[gi]      = hit[gi] & live[gi] &
                                     (y_ext >= HIT_LO_C) & (y_ext <= HIT_HI_C);
            assign wrong_press[gi] = hit[gi] & ~hit_ok[gi];
            assign retire[gi]      = frame_tick & live[gi] & ~hit_ok[gi] &
                                     (y_sum > Y_MAX_C);
            assign advance         = frame_tick & live[gi] & ~hit_ok[gi] &
                                     ~retire[gi];

            always_comb begin
                state_next = state_reg;
                y_next     = y_reg;
                if (hit_ok[gi] || retire[gi]) begin
                    state_next = IDLE;
                    y_next     = '0;
                end else if (advance) begin
                    y_next = y_sum[Y_W-1:0];
                end
                // Only pre-tick IDLE lanes can be granted, so this never
                // collides with the clear above.
                if (spawn_grant[gi]) begin
                    state_next = LIVE;
                    y_next     = '0;
                end
            end

            always_ff @(posedge pclk) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    y_reg     <= '0;
                end else begin
                    state_reg <= state_next;
                    y_reg     <= y_next;
                end
            end

            assign lane_visible[gi]       = live[gi];
            assign lane_y[gi*Y_W +: Y_W]  = y_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Spawn arbitration
    // ------------------------------------------------------------------
    rr_arbiter4 u_arb (
        .req   (spawn_req & ~live),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Retire and hit are disjoint subsets of live, so this cannot underflow.
    assign active_after = count4(live) - count4(retire) - count4(hit_ok);

    assign spawn_ok    = frame_tick && (gap_reg == 8'd0) && arb_valid &&
                         (active_after < 3'(MAX_ACTIVE));
    assign spawn_grant = spawn_ok ? arb_grant : '0;

    always_comb begin
        winner = LANE_L;
        if (arb_grant[LANE_D]) winner = LANE_D;
        if (arb_grant[LANE_U]) winner = LANE_U;
        if (arb_grant[LANE_R]) winner = LANE_R;
    end

    always_comb begin
        ptr_next = ptr_reg;
        gap_next = gap_reg;
        if (spawn_ok) begin
            ptr_next = winner + 2'd1;
        end
        if (frame_tick) begin
            if (spawn_ok) begin
                gap_next = 8'(MIN_GAP);
            end else if (gap_reg != 8'd0) begin
                gap_next = gap_reg - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Score (saturating)
    // ------------------------------------------------------------------
    assign score_sum  = {1'b0, score_reg} + {14'd0, count4(hit_ok)};
    assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            gap_reg         <= '0;
            ptr_reg         <= '0;
            score_reg       <= '0;
            spawn_pulse_reg <= '0;
            hit_pulse_reg   <= '0;
            miss_pulse_reg  <= '0;
        end else begin
            gap_reg         <= gap_next;
            ptr_reg         <= ptr_next;
            score_reg       <= score_next;
            spawn_pulse_reg <= spawn_grant;
            hit_pulse_reg   <= hit_ok;
            miss_pulse_reg  <= retire | wrong_press;
        end
    end

    assign spawn_pulse = spawn_pulse_reg;
    assign hit_pulse   = hit_pulse_reg;
    assign miss_pulse  = miss_pulse_reg;
    assign score       = score_reg;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Directed testbench for arrow_scheduler. Instance dut uses the default
// parameters; instance dut_b uses MIN_GAP=0 and a full-range hit window to
// exercise back-to-back spawns and score saturation in reasonable time.
module tb_arrow_scheduler;

    logic        pclk = 1'b0;
    logic        rst_n, frame_tick;
    logic [3:0]  spawn_req, hit;
    logic [3:0]  lane_visible, spawn_pulse, hit_pulse, miss_pulse;
    logic [31:0] lane_y;
    logic [15:0] score;

    logic        rst_n_b, frame_tick_b;
    logic [3:0]  spawn_req_b, hit_b;
    logic [3:0]  lane_visible_b, spawn_pulse_b, hit_pulse_b, miss_pulse_b;
    logic [31:0] lane_y_b;
    logic [15:0] score_b;

    int checks   = 0;
    int failures = 0;

    always #20 pclk = ~pclk;

    arrow_scheduler dut (
        .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick),
        .spawn_req(spawn_req), .hit(hit),
        .lane_visible(lane_visible), .lane_y(lane_y),
        .spawn_pulse(spawn_pulse), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .score(score)
    );

    arrow_scheduler #(
        .STEP(1), .Y_MAX(255), .HIT_LO(0), .HIT_HI(255),
        .MIN_GAP(0), .MAX_ACTIVE(3)
    ) dut_b (
        .pclk(pclk), .rst_n(rst_n_b), .frame_tick(frame_tick_b),
        .spawn_req(spawn_req_b), .hit(hit_b),
        .lane_visible(lane_visible_b), .lane_y(lane_y_b),
        .spawn_pulse(spawn_pulse_b), .hit_pulse(hit_pulse_b),
        .miss_pulse(miss_pulse_b), .score(score_b)
    );

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_tick = 1'b0; spawn_req = '0; hit = '0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 1'b1; spawn_req = 4'hF; hit = 4'hF;
        rst_n_b = 1'b0; frame_tick_b = 1'b0; spawn_req_b = '0; hit_b = '0;
        cyc();
        cyc();
        frame_tick = 1'b0; spawn_req = '0; hit = '0;
        $display("reset: vis=%b y=%h sp=%b hp=%b mp=%b score=%0d",
                 lane_visible, lane_y, spawn_pulse, hit_pulse, miss_pulse, score);
        checks++; if (lane_visible !== 4'b0) begin failures++; $display("FAIL reset_visible got %b want 0000", lane_visible); end
        checks++; if (lane_y !== 32'h0) begin failures++; $display("FAIL reset_y got %h want 0", lane_y); end
        checks++; if ({spawn_pulse, hit_pulse, miss_pulse} !== 12'h0) begin failures++; $display("FAIL reset_pulses got %h want 000", {spawn_pulse, hit_pulse, miss_pulse}); end
        checks++; if (score !== 16'h0) begin failures++; $display("FAIL reset_score got %h want 0000", score); end
        rst_n = 1'b1;
        rst_n_b = 1'b1;
    endtask

    task automatic test_spawn_gap();
        logic [3:0] exp_sp;
        do_reset();
        spawn_req = 4'b0010; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        $display("spawn lane1: sp=%b vis=%b y=%h", spawn_pulse, lane_visible, lane_y);
        checks++; if (spawn_pulse !== 4'b0010) begin failures++; $display("FAIL spawn_pulse got %b want 0010", spawn_pulse); end
        checks++; if (lane_visible !== 4'b0010) begin failures++; $display("FAIL spawn_visible got %b want 0010", lane_visible); end
        checks++; if (lane_y[15:8] !== 8'd0) begin failures++; $display("FAIL spawn_y got %0d want 0", lane_y[15:8]); end
        cyc();
        checks++; if (spawn_pulse !== 4'b0000) begin failures++; $display("FAIL spawn_pulse_width got %b want 0000", spawn_pulse); end
        spawn_req = 4'b0001; frame_tick = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            exp_sp = (k == 9) ? 4'b0001 : 4'b0000;
            $display("gap tick %0d: sp=%b", k, spawn_pulse);
            checks++; if (spawn_pulse !== exp_sp) begin failures++; $display("FAIL gap_tick%0d got %b want %b", k, spawn_pulse, exp_sp); end
        end
        frame_tick = 1'b0; spawn_req = '0;
        checks++; if (lane_y !== 32'h00000900) begin failures++; $display("FAIL gap_y got %h want 00000900", lane_y); end
    endtask

    task automatic test_retire();
        do_reset();
        spawn_req = 4'b0001; frame_tick = 1'b1;
        cyc();
        spawn_req = '0;
        repeat (199) cyc();
        $display("retire pre: vis=%b y0=%0d mp=%b", lane_visible, lane_y[7:0], miss_pulse);
        checks++; if (lane_y[7:0] !== 8'd199 || lane_visible[0] !== 1'b1) begin failures++; $display("FAIL retire_pre got vis=%b y=%0d want vis=1 y=199", lane_visible[0], lane_y[7:0]); end
        checks++; if (miss_pulse !== 4'b0) begin failures++; $display("FAIL retire_early_miss got %b want 0000", miss_pulse); end
        cyc();
        frame_tick = 1'b0;
        $display("retire: vis=%b y0=%0d mp=%b", lane_visible, lane_y[7:0], miss_pulse);
        checks++; if (lane_visible !== 4'b0) begin failures++; $display("FAIL retire_visible got %b want 0000", lane_visible); end
        checks++; if (miss_pulse !== 4'b0001) begin failures++; $display("FAIL retire_miss got %b want 0001", miss_pulse); end
        checks++; if (lane_y !== 32'h0) begin failures++; $display("FAIL retire_y got %h want 0", lane_y); end
    endtask

    task automatic test_hit_window();
        do_reset();
        spawn_req = 4'b0100; frame_tick = 1'b1;
        cyc();
        spawn_req = '0;
        repeat (160) cyc();
        frame_tick = 1'b0;
        checks++; if (lane_y[23:16] !== 8'd160) begin failures++; $display("FAIL hit_setup_y got %0d want 160", lane_y[23:16]); end
        hit = 4'b0100;
        cyc();
        hit = '0;
        $display("hit y=160: hp=%b mp=%b vis=%b score=%0d", hit_pulse, miss_pulse, lane_visible, score);
        checks++; if (hit_pulse !== 4'b0100) begin failures++; $display("FAIL hit160_pulse got %b want 0100", hit_pulse); end
        checks++; if (miss_pulse !== 4'b0) begin failures++; $display("FAIL hit160_miss got %b want 0000", miss_pulse); end
        checks++; if (score !== 16'd1) begin failures++; $display("FAIL hit160_score got %0d want 1", score); end
        checks++; if (lane_visible !== 4'b0) begin failures++; $display("FAIL hit160_visible got %b want 0000", lane_visible); end
        cyc();
        checks++; if (hit_pulse !== 4'b0) begin failures++; $display("FAIL hit_pulse_width got %b want 0000", hit_pulse); end
        spawn_req = 4'b0100; frame_tick = 1'b1;
        cyc();
        spawn_req = '0;
        checks++; if (spawn_pulse !== 4'b0100) begin failures++; $display("FAIL respawn got %b want 0100", spawn_pulse); end
        repeat (159) cyc();
        frame_tick = 1'b0;
        hit = 4'b0100;
        cyc();
        hit = '0;
        $display("hit y=159: hp=%b mp=%b vis=%b y2=%0d score=%0d", hit_pulse, miss_pulse, lane_visible, lane_y[23:16], score);
        checks++; if (miss_pulse !== 4'b0100 || hit_pulse !== 4'b0) begin failures++; $display("FAIL hit159 got mp=%b hp=%b want mp=0100 hp=0000", miss_pulse, hit_pulse); end
        checks++; if (lane_visible !== 4'b0100 || lane_y[23:16] !== 8'd159) begin failures++; $display("FAIL hit159_state got vis=%b y=%0d want 0100/159", lane_visible, lane_y[23:16]); end
        checks++; if (score !== 16'd1) begin failures++; $display("FAIL hit159_score got %0d want 1", score); end
        hit = 4'b0001;
        cyc();
        hit = '0;
        $display("idle press lane0: mp=%b", miss_pulse);
        checks++; if (miss_pulse !== 4'b0001) begin failures++; $display("FAIL idle_press got %b want 0001", miss_pulse); end
    endtask

    task automatic test_coincident();
        do_reset();
        spawn_req = 4'b0010; frame_tick = 1'b1;
        cyc();
        spawn_req = '0;
        repeat (199) cyc();
        checks++; if (lane_y[15:8] !== 8'd199) begin failures++; $display("FAIL coinc_setup_y got %0d want 199", lane_y[15:8]); end
        hit = 4'b0010;
        cyc();
        hit = '0; frame_tick = 1'b0;
        $display("hit+tick y=199: hp=%b mp=%b vis=%b score=%0d", hit_pulse, miss_pulse, lane_visible, score);
        checks++; if (hit_pulse !== 4'b0010) begin failures++; $display("FAIL coinc_hit got %b want 0010", hit_pulse); end
        checks++; if (miss_pulse !== 4'b0) begin failures++; $display("FAIL coinc_miss got %b want 0000", miss_pulse); end
        checks++; if (lane_visible !== 4'b0 || score !== 16'd1) begin failures++; $display("FAIL coinc_state got vis=%b score=%0d want 0000/1", lane_visible, score); end
        hit = 4'b1000; spawn_req = 4'b1000; frame_tick = 1'b1;
        cyc();
        hit = '0; spawn_req = '0; frame_tick = 1'b0;
        $display("idle press + spawn lane3: sp=%b mp=%b vis=%b", spawn_pulse, miss_pulse, lane_visible);
        checks++; if (spawn_pulse !== 4'b1000 || miss_pulse !== 4'b1000) begin failures++; $display("FAIL press_spawn got sp=%b mp=%b want 1000/1000", spawn_pulse, miss_pulse); end
        checks++; if (lane_visible !== 4'b1000) begin failures++; $display("FAIL press_spawn_vis got %b want 1000", lane_visible); end
    endtask

    task automatic test_reset_midplay();
        spawn_req = 4'b0111; frame_tick = 1'b1;
        repeat (18) cyc();
        frame_tick = 1'b0; spawn_req = '0;
        $display("midplay: vis=%b y=%h", lane_visible, lane_y);
        checks++; if (lane_visible !== 4'b1011) begin failures++; $display("FAIL midplay_vis got %b want 1011", lane_visible); end
        checks++; if (lane_y !== 32'h12000009) begin failures++; $display("FAIL midplay_y got %h want 12000009", lane_y); end
        rst_n = 1'b0; hit = 4'hF; spawn_req = 4'hF; frame_tick = 1'b1;
        cyc();
        rst_n = 1'b1; hit = '0; spawn_req = '0; frame_tick = 1'b0;
        $display("midplay reset: vis=%b y=%h sp=%b hp=%b mp=%b score=%0d",
                 lane_visible, lane_y, spawn_pulse, hit_pulse, miss_pulse, score);
        checks++; if (lane_visible !== 4'b0 || lane_y !== 32'h0) begin failures++; $display("FAIL midreset_lanes got vis=%b y=%h want 0/0", lane_visible, lane_y); end
        checks++; if ({spawn_pulse, hit_pulse, miss_pulse} !== 12'h0 || score !== 16'h0) begin failures++; $display("FAIL midreset_outs got pulses=%h score=%0d want 0/0", {spawn_pulse, hit_pulse, miss_pulse}, score); end
        spawn_req = 4'hF; frame_tick = 1'b1;
        cyc();
        spawn_req = '0; frame_tick = 1'b0;
        $display("post-reset spawn: sp=%b", spawn_pulse);
        checks++; if (spawn_pulse !== 4'b0001) begin failures++; $display("FAIL postreset_spawn got %b want 0001", spawn_pulse); end
    endtask

    task automatic test_max_active();
        logic [3:0] exp_tab [4];
        exp_tab[0] = 4'b0001; exp_tab[1] = 4'b0010;
        exp_tab[2] = 4'b0100; exp_tab[3] = 4'b0000;
        rst_n_b = 1'b0;
        cyc();
        rst_n_b = 1'b1; spawn_req_b = 4'hF; frame_tick_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            $display("max_active tick %0d: sp=%b vis=%b", k, spawn_pulse_b, lane_visible_b);
            checks++; if (spawn_pulse_b !== exp_tab[k]) begin failures++; $display("FAIL max_active_tick%0d got %b want %b", k, spawn_pulse_b, exp_tab[k]); end
        end
        frame_tick_b = 1'b0; spawn_req_b = '0;
        hit_b = 4'b0001;
        cyc();
        hit_b = '0;
        checks++; if (hit_pulse_b !== 4'b0001) begin failures++; $display("FAIL max_active_hit got %b want 0001", hit_pulse_b); end
        spawn_req_b = 4'hF; frame_tick_b = 1'b1;
        cyc();
        spawn_req_b = '0; frame_tick_b = 1'b0;
        $display("pointer check: sp=%b vis=%b y=%h", spawn_pulse_b, lane_visible_b, lane_y_b);
        checks++; if (spawn_pulse_b !== 4'b1000) begin failures++; $display("FAIL pointer_spawn got %b want 1000", spawn_pulse_b); end
        checks++; if (lane_visible_b !== 4'b1110 || lane_y_b !== 32'h00020300) begin failures++; $display("FAIL pointer_state got vis=%b y=%h want 1110/00020300", lane_visible_b, lane_y_b); end
    endtask

    task automatic test_score_saturation();
        int hit_cnt;
        hit_cnt = 0;
        rst_n_b = 1'b0;
        cyc();
        rst_n_b = 1'b1; spawn_req_b = 4'hF; frame_tick_b = 1'b1;
        for (int n = 1; n <= 65540; n++) begin
            hit_b = lane_visible_b;
            cyc();
            if (hit_pulse_b != 4'b0) hit_cnt++;
            if (n == 1001) begin
                $display("saturation cycle %0d: score=%0d", n, score_b);
                checks++; if (score_b !== 16'd1000) begin failures++; $display("FAIL score_1000 got %0d want 1000", score_b); end
            end
            if (n == 65536) begin
                $display("saturation cycle %0d: score=%h", n, score_b);
                checks++; if (score_b !== 16'hFFFF) begin failures++; $display("FAIL score_max got %h want ffff", score_b); end
            end
        end
        hit_b = '0; spawn_req_b = '0; frame_tick_b = 1'b0;
        $display("saturation end: score=%h hits=%0d hp=%b", score_b, hit_cnt, hit_pulse_b);
        checks++; if (score_b !== 16'hFFFF) begin failures++; $display("FAIL score_saturated got %h want ffff", score_b); end
        checks++; if (hit_pulse_b === 4'b0) begin failures++; $display("FAIL sat_hit_pulse got %b want nonzero", hit_pulse_b); end
        checks++; if (hit_cnt != 65539) begin failures++; $display("FAIL sat_hit_count got %0d want 65539", hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_spawn_gap();
        test_retire();
        test_hit_window();
        test_coincident();
        test_reset_midplay();
        test_max_active();
        test_score_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/arrow_scheduler.md
# arrow_scheduler

Sequencing controller for the four falling-arrow lanes (left, down, up, right) of the 640x480 rhythm-game display. It decides when each lane spawns an arrow from its random request line, advances every live arrow once per video frame, retires arrows that leave the playfield, and judges player key presses against a hit window. Its lane_visible/lane_y outputs feed the arrow renderer directly, replacing the per-lane spawn/frame logic inside the VGA timing block.

## Interface
Parameters:
- STEP, 1: rows added to an arrow's y per frame tick (1..15)
- Y_MAX, 199: last valid y; an arrow whose next y would exceed this retires
- HIT_LO, 160: lowest y (inclusive) counted as a hit
- HIT_HI, 199: highest y (inclusive) counted as a hit
- MIN_GAP, 8: frame ticks after a spawn before another spawn is allowed (0..255)
- MAX_ACTIVE, 3: maximum simultaneously visible arrows (1..4)

Ports:
- pclk  in  1  pixel clock, 25 MHz; the only clock
- rst_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (vc==0, hc==0)
- spawn_req  in  4  level; lane i wants a spawn (random generator hit)
- hit  in  4  one-cycle pulse; debounced key press for lane i
- lane_visible  out  4  lane i arrow live
- lane_y  out  32  lane i y offset at bits [8i+7:8i]
- spawn_pulse  out  4  one-cycle; lane i spawned
- hit_pulse  out  4  one-cycle; lane i press judged a hit
- miss_pulse  out  4  one-cycle; lane i arrow missed or wrong press
- score  out  16  hit count, saturates at 16'hFFFF

Lane order: 0=left, 1=down, 2=up, 3=right.

## Operation
- Per-lane state: IDLE (visible=0) or LIVE (visible=1, y). Global: gap counter (8 b), round-robin pointer (2 b), score.
- Hit judging (any cycle, on hit[i]): LIVE with HIT_LO<=y<=HIT_HI -> lane to IDLE, hit_pulse[i], score+1 (saturating). LIVE out of window or IDLE -> miss_pulse[i] only; lane state unchanged.
- On frame_tick, per lane not cleared by a hit this cycle: LIVE and y+STEP>Y_MAX (9-bit compare) -> IDLE, y cleared, miss_pulse[i]. Otherwise LIVE -> y<=y+STEP.
- Spawn on frame_tick only, at most one lane per tick. Eligible: spawn_req[i] & pre-tick IDLE. Allowed when gap counter==0 and (pre-tick live count - retires - hits this cycle) < MAX_ACTIVE. Winner: round-robin from pointer, pointer <= winner+1 mod 4. Winner -> LIVE, y=0, spawn_pulse, gap<=MIN_GAP.
- Gap counter decrements on every frame_tick without a spawn, saturating at 0.
- A lane retiring or hit this cycle is not eligible until the next tick.
- miss_pulse[i] is the OR of retire and wrong press; never two pulses per lane per cycle.

## Timing
- All outputs registered; state and pulses update on the pclk edge after the sampled frame_tick/hit cycle (1-cycle latency).
- Pulses are high exactly one cycle.
- Same-cycle hit and frame_tick on a LIVE lane: hit judged on pre-tick y; if hit, no advance and no retire miss.
- Same-cycle hit on IDLE lane and spawn of that lane: wrong-press miss and spawn both occur.
- Reset: lane_visible=0, lane_y=0, all pulses 0, score=0, gap=0, pointer=0; reset mid-play discards all arrows immediately, pending inputs in that cycle ignored.
- spawn_req ignored outside frame_tick cycles.

## Structure
- Shared package arrow_pkg: NUM_LANES=4, Y_W=8, lane index constants LANE_L/D/U/R, lane state enum {IDLE, LIVE}.
- One sub-module: rr_arbiter4 (4-way round-robin, request/pointer in, one-hot grant + valid out, combinational); pointer register lives in arrow_scheduler.

## Test plan
- Reset, spawn_req=4'b0010, one frame_tick -> next cycle spawn_pulse=4'b0010, lane_visible=4'b0010, lane_y[15:8]=0; gap=8 blocks spawns for 8 ticks.
- MIN_GAP=0, spawn_req=4'b1111 held, 4 ticks -> spawns lanes 0,1,2 then none (MAX_ACTIVE=3); pointer ends at 3.
- Lane 0 live, 199 ticks with STEP=1 -> y=199; next tick -> lane_visible[0]=0, miss_pulse[0]=1.
- Lane 2 at y=160, hit[2] -> hit_pulse[2]=1, score=1, lane cleared; at y=159 -> miss_pulse[2]=1, lane stays live.
- Lane 1 at y=199, hit[1] coincident with frame_tick -> hit_pulse[1]=1, no miss_pulse[1]; score preset 16'hFFFF stays 16'hFFFF.
- rst_n=0 for one cycle with three lanes live -> all outputs zero next cycle.
